// File: rtl/uart_bus_pkg.sv
// Shared types and default timing for the two-requester UART bus arbiter.
package uart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam int unsigned DEF_SETUP_CYC  = 1;
    localparam int unsigned DEF_STROBE_CYC = 2;
    localparam int unsigned DEF_HOLD_CYC   = 1;

    function automatic int unsigned max3(int unsigned x, int unsigned y, int unsigned z);
        int unsigned m;
        m = (x > y) ? x : y;
        return (m > z) ? m : z;
    endfunction

endpackage

// File: rtl/uart_bus_arb_if.sv
// Requester and UART-bus signal bundle; master is the arbiter side.
interface uart_bus_arb_if;
    logic       req0, req1;
    logic       we0, we1;
    logic       ch0, ch1;
    logic [2:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       done0, done1;
    logic [7:0] rdata;
    logic       busy;
    logic [2:0] a;
    logic       cs_0, cs_1;
    logic       rd_, wr_;
    logic [7:0] dbus_o;
    logic       dbus_oe;
    logic [7:0] dbus_i;

    modport master (
        input  req0, req1, we0, we1, ch0, ch1, addr0, addr1, wdata0, wdata1, dbus_i,
        output done0, done1, rdata, busy, a, cs_0, cs_1, rd_, wr_, dbus_o, dbus_oe
    );

    modport slave (
        output req0, req1, we0, we1, ch0, ch1, addr0, addr1, wdata0, wdata1, dbus_i,
        input  done0, done1, rdata, busy, a, cs_0, cs_1, rd_, wr_, dbus_o, dbus_oe
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the requester not granted last wins a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    logic last;

    always_comb begin
        gnt = req;
        if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
    end

    // Reset value 1 gives requester 0 priority on the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last <= 1'b1;
        else if (update) last <= gnt[1];
    end
endmodule

// File: rtl/uart_bus_arb.sv
// Arbitrates two requesters onto a UART register bus with setup/strobe/hold timing.
module uart_bus_arb
    import uart_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
    parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
    parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
    input  logic           clkin,
    input  logic           reset,
    uart_bus_arb_if.master bus
);
    localparam int unsigned MAX_CYC = max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q, gid_q, busy_q, rd_q, wr_q, oe_q;
    logic [1:0]       cs_q, done_q;
    logic [2:0]       a_q;
    logic [7:0]       dout_q, rdata_q;

    logic [1:0] req_v, arb_req, gnt;
    logic       g_we, g_ch;
    logic [2:0] g_addr;
    logic [7:0] g_wdata;
    logic       setup_last, strobe_last, hold_last;

    // The requester just served is masked during its done cycle.
    assign req_v   = {bus.req1, bus.req0} & ~done_q;
    assign arb_req = (state == ST_IDLE) ? req_v : 2'b00;

    rr_arb2 u_arb (
        .clk    (clkin),
        .rst    (reset),
        .req    (arb_req),
        .update (|gnt),
        .gnt    (gnt)
    );

    assign g_we    = gnt[1] ? bus.we1    : bus.we0;
    assign g_ch    = gnt[1] ? bus.ch1    : bus.ch0;
    assign g_addr  = gnt[1] ? bus.addr1  : bus.addr0;
    assign g_wdata = gnt[1] ? bus.wdata1 : bus.wdata0;

    assign setup_last  = (cnt == CNT_W'(SETUP_CYC - 1));
    assign strobe_last = (cnt == CNT_W'(STROBE_CYC - 1));
    assign hold_last   = (cnt == CNT_W'(HOLD_CYC - 1));

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            gid_q   <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 2'b00;
            a_q     <= 3'd0;
            rd_q    <= 1'b1;
            wr_q    <= 1'b1;
            oe_q    <= 1'b0;
            dout_q  <= 8'h00;
            done_q  <= 2'b00;
            rdata_q <= 8'h00;
        end else begin
            done_q <= 2'b00;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        state  <= ST_SETUP;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        gid_q  <= gnt[1];
                        we_q   <= g_we;
                        cs_q   <= g_ch ? 2'b10 : 2'b01;
                        a_q    <= g_addr;
                        oe_q   <= g_we;
                        dout_q <= g_we ? g_wdata : 8'h00;
                    end
                end
                ST_SETUP: begin
                    if (setup_last) begin
                        state <= ST_STROBE;
                        cnt   <= '0;
                        if (we_q) wr_q <= 1'b0;
                        else      rd_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_STROBE: begin
                    if (strobe_last) begin
                        state <= ST_HOLD;
                        cnt   <= '0;
                        rd_q  <= 1'b1;
                        wr_q  <= 1'b1;
                        if (!we_q) rdata_q <= bus.dbus_i;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (hold_last) begin
                        state  <= ST_IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                        cs_q   <= 2'b00;
                        a_q    <= 3'd0;
                        oe_q   <= 1'b0;
                        dout_q <= 8'h00;
                        done_q <= gid_q ? 2'b10 : 2'b01;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.done0   = done_q[0];
    assign bus.done1   = done_q[1];
    assign bus.rdata   = rdata_q;
    assign bus.busy    = busy_q;
    assign bus.a       = a_q;
    assign bus.cs_0    = cs_q[0];
    assign bus.cs_1    = cs_q[1];
    assign bus.rd_     = rd_q;
    assign bus.wr_     = wr_q;
    assign bus.dbus_o  = dout_q;
    assign bus.dbus_oe = oe_q;
endmodule
